// File: rtl/video_timing_compositor.sv
// Raster timing generator and fixed-priority sprite layer compositor.
// Produces raster coordinates and syncs, then emits registered RGB/DE and a per-frame collision pulse.
module video_timing_compositor #(
  parameter int          H_ACTIVE   = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33,
  parameter logic        SYNC_POL   = 1'b0,
  parameter int          NUM_LAYERS = 2,
  parameter logic [23:0] BG_RGB     = 24'h000000
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  output logic [15:0]                o_x,
  output logic [15:0]                o_y,
  output logic                       o_v_sync,
  input  logic [24*NUM_LAYERS-1:0]   i_layer_rgb,
  input  logic [NUM_LAYERS-1:0]      i_layer_hit,
  output logic [7:0]                 o_red,
  output logic [7:0]                 o_green,
  output logic [7:0]                 o_blue,
  output logic                       o_h_sync,
  output logic                       o_v_sync_d,
  output logic                       o_de,
  output logic                       o_frame_start,
  output logic                       o_collision
);

  localparam logic [15:0] H_TOTAL  = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [15:0] V_TOTAL  = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [15:0] H_ACT    = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT    = 16'(V_ACTIVE);
  localparam logic [15:0] HS_START = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_START = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);

  logic [15:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [23:0] rgb_q, rgb_d;
  logic        de_q, de_d, h_sync_q, h_sync_d, v_sync_q, v_sync_d;
  logic        frame_start_q, frame_start_d, collision_q, collision_d, flag_q, flag_d;
  logic        h_wrap, v_last, active, hsync_raw, vsync_raw, seen, overlap, last_px;
  logic [23:0] pix;

  always_comb begin
    h_wrap    = (h_cnt_q == H_TOTAL - 16'd1);
    v_last    = (v_cnt_q == V_TOTAL - 16'd1);
    h_cnt_d   = h_wrap ? 16'd0 : h_cnt_q + 16'd1;
    v_cnt_d   = v_cnt_q;
    if (h_wrap) v_cnt_d = v_last ? 16'd0 : v_cnt_q + 16'd1;

    active    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hsync_raw = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
    vsync_raw = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
    last_px   = h_wrap && v_last;

    // Ascending scan: the first hit found owns the pixel, any later hit is an overlap.
    pix     = BG_RGB;
    seen    = 1'b0;
    overlap = 1'b0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (i_layer_hit[k]) begin
        if (seen) overlap = 1'b1;
        else      pix = i_layer_rgb[24*k +: 24];
        seen = 1'b1;
      end
    end

    rgb_d         = active ? pix : 24'd0;
    de_d          = active;
    h_sync_d      = hsync_raw ? SYNC_POL : ~SYNC_POL;
    v_sync_d      = vsync_raw ? SYNC_POL : ~SYNC_POL;
    frame_start_d = (h_cnt_q == 16'd0) && (v_cnt_q == 16'd0);
    collision_d   = last_px && (flag_q || (active && overlap));
    flag_d        = last_px ? 1'b0 : (flag_q || (active && overlap));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      h_cnt_q       <= 16'd0;
      v_cnt_q       <= 16'd0;
      rgb_q         <= 24'd0;
      de_q          <= 1'b0;
      h_sync_q      <= ~SYNC_POL;
      v_sync_q      <= ~SYNC_POL;
      frame_start_q <= 1'b0;
      collision_q   <= 1'b0;
      flag_q        <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      rgb_q         <= rgb_d;
      de_q          <= de_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      frame_start_q <= frame_start_d;
      collision_q   <= collision_d;
      flag_q        <= flag_d;
    end
  end

  assign o_x           = h_cnt_q;
  assign o_y           = v_cnt_q;
  assign o_v_sync      = vsync_raw ? SYNC_POL : ~SYNC_POL;
  assign o_red         = rgb_q[23:16];
  assign o_green       = rgb_q[15:8];
  assign o_blue        = rgb_q[7:0];
  assign o_h_sync      = h_sync_q;
  assign o_v_sync_d    = v_sync_q;
  assign o_de          = de_q;
  assign o_frame_start = frame_start_q;
  assign o_collision   = collision_q;

endmodule
